mmio_fifo_sched: RTL and testbench
==================================

Name: mmio_fifo_sched

Overview:
- Shares one shift-register FIFO (ports en/d/q; each en pulse shifts d in; q is the word pushed DEPTH pushes earlier) between two requesters.
  - Host path: MMIO writes from the CCI-P AFU, which cannot be back-pressured.
  - Aux path: an on-FPGA producer using a valid/ready handshake.
- Arbitrates round-robin between the two, sequences a flush that fills the FIFO with zeros, and tracks occupancy.
- Exports a 64-bit status word and counters for MMIO readback.
- Sits between the AFU MMIO decode and the fifo instance.

Parameters:
- DEPTH, 8, number of shift stages in the attached fifo (2..255).
- WIDTH, 64, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- host_wr_valid  in  1  one-cycle pulse: MMIO write to the FIFO data address.
- host_wr_data  in  WIDTH  data qualified by host_wr_valid.
- aux_valid  in  1  aux producer request.
- aux_data  in  WIDTH  aux data.
- aux_ready  out  1  aux word accepted this cycle (combinational).
- flush_req  in  1  one-cycle pulse: start a flush.
- fifo_en  out  1  shift enable to fifo (registered).
- fifo_d  out  WIDTH  shift data to fifo (registered).
- fifo_q  in  WIDTH  fifo oldest word.
- rd_data  out  WIDTH  fifo_q when out_valid, else 0 (combinational).
- out_valid  out  1  fill_count == DEPTH.
- busy  out  1  state == FLUSH.
- status  out  64  {drop_cnt[7:0], 7'b0, host_pend, 7'b0, busy, fill_count[7:0], push_cnt[31:0]}.

Behaviour:
- Reset (async assert, sync release) clears all registers:
  - fifo_en=0, fifo_d=0, fill_count=0, push_cnt=0, drop_cnt=0, host_pend=0, rr_last=AUX (host wins first tie), state=IDLE.
  - Outputs: aux_ready=0, busy=0, out_valid=0, rd_data=0.
- Host skid register (1 entry):
  - host_wr_valid with host_pend=0: latch data, set host_pend next cycle.
  - host_wr_valid with host_pend=1 and no host grant this cycle: new word dropped, drop_cnt += 1, saturating at 255. The pending word is kept.
  - host_wr_valid in the same cycle host_pend is granted: new word loads the skid and host_pend stays 1. No drop.
- Arbitration, state IDLE, evaluated combinationally each cycle:
  - Candidates are host_pend and aux_valid.
  - Only one candidate: it wins.
  - Both: the requester that did not win last time wins (round-robin). rr_last updates only on a grant.
  - aux_ready = grant_aux.
  - At most one push per cycle.
- Push:
  - Granted word appears on fifo_d with fifo_en=1 in the next cycle (latency 1).
  - fifo_en is 0 in any cycle following no grant.
  - Each push: push_cnt += 1 (wraps at 2^32); fill_count += 1, saturating at DEPTH.
- States:
  - IDLE -> FLUSH on flush_req. Checked before arbitration: no grant in that cycle; aux_ready=0.
  - FLUSH: drives fifo_en=1, fifo_d=0 for exactly DEPTH consecutive cycles, using a cycle counter 0..DEPTH-1.
  - FLUSH: aux_ready=0 and no grants. host_wr_valid still loads the skid or drops per the skid rules.
  - FLUSH -> IDLE after the DEPTH-th shift. Then fill_count=0 and push_cnt is unchanged. A pending host word is granted in the first IDLE cycle.
  - flush_req while in FLUSH is ignored; the flush is not restarted.
- out_valid goes high on the cycle after the DEPTH-th push following reset or flush. rd_data then equals the oldest of the last DEPTH pushed words.
- Reset mid-flush: immediate return to IDLE with all counters cleared. FIFO contents are undefined until DEPTH new pushes (out_valid=0 guards them).

Test Plan:
- Reset, then single host write 0xA5 -> host_pend=1 for 1 cycle; fifo_en=1 with fifo_d=0xA5 two cycles after the pulse; push_cnt=1, fill_count=1, out_valid=0.
- DEPTH=8, aux_valid held with data 1..8, no host traffic -> aux_ready=1 for 8 cycles; out_valid rises after 8th push; rd_data=1; 9th push (9) makes rd_data=2.
- host_pend and aux_valid both asserted continuously -> grants alternate host, aux, host, aux starting with host; one fifo_en per cycle.
- Host pulses on two consecutive cycles while aux holds the grant -> second word dropped, drop_cnt=1; first word pushed on the next host grant.
- After fill_count=8, flush_req -> busy=1 for 8 cycles, fifo_en=1, fifo_d=0 each cycle; aux_ready=0 throughout; then fill_count=0, out_valid=0, push_cnt unchanged.
- Deassert rst_n midway through a flush (cycle 3 of 8) -> fifo_en, busy, and all counters read 0 in the same cycle; after release an aux push is accepted immediately.

Source files
------------

// File: rtl/mmio_fifo_sched.sv
// Arbitrates host MMIO writes (via a one-entry skid) and an aux valid/ready producer
// onto a shared shift-register FIFO, with zero-fill flush sequencing and occupancy tracking.
module mmio_fifo_sched #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             host_wr_valid,
   input  logic [WIDTH-1:0] host_wr_data,
   input  logic             aux_valid,
   input  logic [WIDTH-1:0] aux_data,
   output logic             aux_ready,
   input  logic             flush_req,
   output logic             fifo_en,
   output logic [WIDTH-1:0] fifo_d,
   input  logic [WIDTH-1:0] fifo_q,
   output logic [WIDTH-1:0] rd_data,
   output logic             out_valid,
   output logic             busy,
   output logic [63:0]      status
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic           RR_HOST = 1'b0;
   localparam logic           RR_AUX  = 1'b1;
   localparam logic [7:0]     DEPTH_C = 8'(DEPTH);
   localparam logic [7:0]     LAST_C  = 8'(DEPTH - 1);
   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

   state_t           state_r;
   state_t           state_next_s;
   logic             host_pend_r;
   logic [WIDTH-1:0] host_data_r;
   logic             rr_last_r;
   logic [7:0]       fill_cnt_r;
   logic [7:0]       drop_cnt_r;
   logic [7:0]       flush_cnt_r;
   logic [31:0]      push_cnt_r;
   logic             fifo_en_r;
   logic [WIDTH-1:0] fifo_d_r;
   logic             grant_host_s;
   logic             grant_aux_s;
   logic             push_event_s;

   // Next-state decode and round-robin grant; a flush request pre-empts arbitration.
   always_comb begin
      state_next_s = state_r;
      grant_host_s = 1'b0;
      grant_aux_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (flush_req) begin
               state_next_s = FLUSH;
            end else begin
               grant_host_s = host_pend_r & (~aux_valid | (rr_last_r == RR_AUX));
               grant_aux_s  = aux_valid & (~host_pend_r | (rr_last_r == RR_HOST));
            end
         end
         FLUSH: begin
            if (flush_cnt_r == LAST_C) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = FLUSH;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Shifts seen by the fifo while IDLE are data pushes; those during FLUSH are zero fills.
   assign push_event_s = fifo_en_r & (state_r == IDLE);

   // State register and flush shift counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         flush_cnt_r <= 8'd0;
      end else begin
         state_r <= state_next_s;
         if (state_r == FLUSH) begin
            flush_cnt_r <= flush_cnt_r + 8'd1;
         end else begin
            flush_cnt_r <= 8'd0;
         end
      end
   end

   // Host skid entry and drop counter; a word arriving as the pending one is granted refills the skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_pend_r <= 1'b0;
         host_data_r <= ZERO_W;
         drop_cnt_r  <= 8'd0;
      end else begin
         if (host_wr_valid && (!host_pend_r || grant_host_s)) begin
            host_pend_r <= 1'b1;
            host_data_r <= host_wr_data;
         end else if (host_wr_valid) begin
            if (drop_cnt_r != 8'hFF) begin
               drop_cnt_r <= drop_cnt_r + 8'd1;
            end
         end else if (grant_host_s) begin
            host_pend_r <= 1'b0;
         end
      end
   end

   // Registered fifo drive and round-robin history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_en_r <= 1'b0;
         fifo_d_r  <= ZERO_W;
         rr_last_r <= RR_AUX;
      end else begin
         fifo_en_r <= grant_host_s | grant_aux_s | (state_next_s == FLUSH);
         if (grant_host_s) begin
            fifo_d_r  <= host_data_r;
            rr_last_r <= RR_HOST;
         end else if (grant_aux_s) begin
            fifo_d_r  <= aux_data;
            rr_last_r <= RR_AUX;
         end else begin
            fifo_d_r <= ZERO_W;
         end
      end
   end

   // Push and occupancy counters; occupancy restarts from zero for the whole flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_cnt_r <= 32'd0;
         fill_cnt_r <= 8'd0;
      end else begin
         if (push_event_s) begin
            push_cnt_r <= push_cnt_r + 32'd1;
         end
         if ((state_next_s == FLUSH) || (state_r == FLUSH)) begin
            fill_cnt_r <= 8'd0;
         end else if (push_event_s && (fill_cnt_r != DEPTH_C)) begin
            fill_cnt_r <= fill_cnt_r + 8'd1;
         end
      end
   end

   assign aux_ready = grant_aux_s;
   assign fifo_en   = fifo_en_r;
   assign fifo_d    = fifo_d_r;
   assign busy      = (state_r == FLUSH);
   assign out_valid = (fill_cnt_r == DEPTH_C);
   assign rd_data   = out_valid ? fifo_q : ZERO_W;
   assign status    = {drop_cnt_r, 7'b0, host_pend_r, 7'b0, busy, fill_cnt_r, push_cnt_r};

endmodule

// File: tb/tb_mmio_fifo_sched.sv
// Directed bench for mmio_fifo_sched with a behavioural shift-register fifo attached.
module tb_mmio_fifo_sched;
   localparam int DEPTH = 8;
   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             host_wr_valid;
   logic [WIDTH-1:0] host_wr_data;
   logic             aux_valid;
   logic [WIDTH-1:0] aux_data;
   logic             aux_ready;
   logic             flush_req;
   logic             fifo_en;
   logic [WIDTH-1:0] fifo_d;
   logic [WIDTH-1:0] fifo_q;
   logic [WIDTH-1:0] rd_data;
   logic             out_valid;
   logic             busy;
   logic [63:0]      status;
   logic [WIDTH-1:0] fmem [DEPTH];

   int n_cmp = 0;
   int n_bad = 0;

   mmio_fifo_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data),
      .aux_valid(aux_valid), .aux_data(aux_data), .aux_ready(aux_ready),
      .flush_req(flush_req),
      .fifo_en(fifo_en), .fifo_d(fifo_d), .fifo_q(fifo_q),
      .rd_data(rd_data), .out_valid(out_valid), .busy(busy), .status(status)
   );

   always #5 clk = ~clk;

   // Attached fifo: plain shift register, oldest word at the last stage.
   always @(posedge clk) begin
      if (fifo_en) begin
         fmem[0] <= fifo_d;
         for (int s = 1; s < DEPTH; s++) fmem[s] <= fmem[s-1];
      end
   end
   assign fifo_q = fmem[DEPTH-1];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; host_wr_valid = 1'b0; host_wr_data = '0;
      aux_valid = 1'b0; aux_data = '0; flush_req = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_fifo_en", 64'(fifo_en), 64'd0);
      check("rst_status", status, 64'd0);
      check("rst_aux_ready", 64'(aux_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      rst_n = 1'b1;
      tick();

      // single host write
      host_wr_valid = 1'b1; host_wr_data = 64'hA5; tick();
      host_wr_valid = 1'b0; #1;
      check("t1_pend", 64'(status[48]), 64'd1);
      check("t1_en_early", 64'(fifo_en), 64'd0);
      tick();
      check("t1_en", 64'(fifo_en), 64'd1);
      check("t1_d", fifo_d, 64'hA5);
      check("t1_pend_clr", 64'(status[48]), 64'd0);
      tick();
      check("t1_push", 64'(status[31:0]), 64'd1);
      check("t1_fill", 64'(status[39:32]), 64'd1);
      check("t1_out_valid", 64'(out_valid), 64'd0);
      check("t1_en_idle", 64'(fifo_en), 64'd0);
      do_reset();

      // aux fill 1..9
      for (int i = 1; i <= 9; i++) begin
         aux_valid = 1'b1; aux_data = 64'(i); #1;
         check("t2_aux_ready", 64'(aux_ready), 64'd1);
         if (i == 9) check("t2_not_full", 64'(out_valid), 64'd0);
         tick();
      end
      aux_valid = 1'b0; #1;
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_rd_first", rd_data, 64'd1);
      check("t2_d9", fifo_d, 64'd9);
      check("t2_fill", 64'(status[39:32]), 64'd8);
      tick();
      check("t2_rd_second", rd_data, 64'd2);
      check("t2_push", 64'(status[31:0]), 64'd9);
      check("t2_fill_sat", 64'(status[39:32]), 64'd8);

      // flush with aux blocked, host word parked, repeat flush_req ignored
      flush_req = 1'b1; aux_valid = 1'b1; aux_data = 64'hBB; #1;
      check("t5_req_no_grant", 64'(aux_ready), 64'd0);
      tick();
      for (int k = 0; k < DEPTH; k++) begin
         flush_req = (k == 3); host_wr_valid = (k == 2); host_wr_data = 64'h77;
         #1;
         check("t5_busy", 64'(busy), 64'd1);
         check("t5_en", 64'(fifo_en), 64'd1);
         check("t5_d", fifo_d, 64'd0);
         check("t5_aux_ready", 64'(aux_ready), 64'd0);
         tick();
      end
      flush_req = 1'b0; host_wr_valid = 1'b0; aux_valid = 1'b0; #1;
      check("t5_busy_end", 64'(busy), 64'd0);
      check("t5_fill", 64'(status[39:32]), 64'd0);
      check("t5_out_valid", 64'(out_valid), 64'd0);
      check("t5_push", 64'(status[31:0]), 64'd9);
      check("t5_pend", 64'(status[48]), 64'd1);
      tick();
      check("t5_host_en", 64'(fifo_en), 64'd1);
      check("t5_host_d", fifo_d, 64'h77);
      tick();
      check("t5_push_after", 64'(status[31:0]), 64'd10);
      check("t5_fill_after", 64'(status[39:32]), 64'd1);
      do_reset();

      // round robin: host first, then alternate
      host_wr_valid = 1'b1; host_wr_data = 64'h1000; tick();
      for (int j = 0; j <= 6; j++) begin
         aux_valid = (j < 6); aux_data = 64'h2000 + 64'(j / 2);
         host_wr_valid = ((j % 2) == 0) && (j < 6);
         host_wr_data = 64'h1000 + 64'(j / 2 + 1);
         #1;
         check("t3_aux_ready", 64'(aux_ready), 64'((j % 2 == 1) && (j < 6)));
         if (j > 0) begin
            check("t3_en", 64'(fifo_en), 64'd1);
            check("t3_d", fifo_d, (((j - 1) % 2) == 0) ? 64'h1000 + 64'((j - 1) / 2)
                                                        : 64'h2000 + 64'((j - 1) / 2));
         end
         tick();
      end
      host_wr_valid = 1'b0; aux_valid = 1'b0; #1;
      check("t3_d_last", fifo_d, 64'h1003);
      check("t3_no_drop", 64'(status[63:56]), 64'd0);

      // drop while aux holds the grant
      tick();
      host_wr_valid = 1'b1; host_wr_data = 64'h3001; tick();
      host_wr_data = 64'h3002; aux_valid = 1'b1; aux_data = 64'h4001; #1;
      check("t4_aux_wins", 64'(aux_ready), 64'd1);
      tick();
      host_wr_valid = 1'b0; aux_valid = 1'b0; #1;
      check("t4_drop", 64'(status[63:56]), 64'd1);
      check("t4_pend", 64'(status[48]), 64'd1);
      check("t4_aux_d", fifo_d, 64'h4001);
      tick();
      check("t4_host_en", 64'(fifo_en), 64'd1);
      check("t4_host_d", fifo_d, 64'h3001);
      check("t4_pend_clr", 64'(status[48]), 64'd0);

      // reset during flush cycle 3
      tick();
      flush_req = 1'b1; tick();
      flush_req = 1'b0; tick();
      tick();
      check("t6_busy_mid", 64'(busy), 64'd1);
      rst_n = 1'b0; #1;
      check("t6_en", 64'(fifo_en), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_status", status, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      aux_valid = 1'b1; aux_data = 64'h5555; #1;
      check("t6_aux_ready", 64'(aux_ready), 64'd1);
      tick();
      aux_valid = 1'b0; #1;
      check("t6_en_push", 64'(fifo_en), 64'd1);
      check("t6_d_push", fifo_d, 64'h5555);
      tick();
      check("t6_push", 64'(status[31:0]), 64'd1);
      check("t6_fill", 64'(status[39:32]), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
